// File: rtl/led_step_sequencer.sv
// Timed, button-controlled 3-bit step code feeding the 3-8 LED decoder.
// Debounces run/pause and direction buttons and steps a wrapping index on a prescaled tick.

module led_btn_debounce #(
  parameter int unsigned DEB_CNT = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Counter only runs while the synchronised level disagrees with the accepted level
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = stable_dly_q & ~stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_n_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

module led_step_sequencer #(
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned DEB_CNT  = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_n,
  input  logic       btn_dir_n,
  output logic [2:0] code_n,
  output logic [2:0] index,
  output logic       running,
  output logic       dir,
  output logic       tick
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic {
    S_PAUSE = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d;
  logic             tick_q, tick_d;
  logic             step_c;
  logic             run_press, dir_press;

  led_btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_run (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_run_n),
    .press_o (run_press)
  );

  led_btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dir (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_dir_n),
    .press_o (dir_press)
  );

  // Step uses the current dir, so a same-cycle dir press only affects later steps
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      S_PAUSE: begin
        if (run_press) state_d = S_RUN;
      end
      S_RUN: begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          step_c = 1'b1;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        if (run_press) state_d = S_PAUSE;
      end
      default: state_d = S_PAUSE;
    endcase
    if (dir_press) dir_d = ~dir_q;
    if (step_c) begin
      idx_d  = dir_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PAUSE;
      dir_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= 3'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  assign index   = idx_q;
  assign code_n  = ~idx_q;
  assign running = (state_q == S_RUN);
  assign dir     = dir_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Scoreboard bench for led_step_sequencer with TICK_DIV=4, DEB_CNT=3.
// Expected output events (tick, running/dir/index changes) are queued with the edge they must appear on.

module tb_led_step_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run_n;
  logic       btn_dir_n;
  logic [2:0] code_n;
  logic [2:0] index;
  logic       running;
  logic       dir;
  logic       tick;

  led_step_sequencer #(.TICK_DIV(4), .DEB_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run_n (btn_run_n),
    .btn_dir_n (btn_dir_n),
    .code_n    (code_n),
    .index     (index),
    .running   (running),
    .dir       (dir),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    logic [2:0] idx;
    logic       run;
    logic       dr;
    logic       tk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ec = 0;
  logic mon_en = 1'b0;
  logic [2:0] prev_idx;
  logic       prev_run;
  logic       prev_dir;

  always @(posedge clk) ec <= ec + 1;

  task automatic push(input int at, input logic [2:0] idx, input logic run,
                      input logic dr, input logic tk);
    exp_t e;
    e.at_edge = at;
    e.idx     = idx;
    e.run     = run;
    e.dr      = dr;
    e.tk      = tk;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_until(input int e);
    while (ec < e) @(negedge clk);
  endtask

  // Monitor: any tick or visible state change is an output event
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] exp_code;
    if (mon_en && (tick === 1'b1 || running !== prev_run || dir !== prev_dir ||
                   index !== prev_idx)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: edge=%0d index=%0d running=%b dir=%b tick=%b",
                 ec, index, running, dir, tick);
      end else begin
        e = q.pop_front();
        exp_code = ~e.idx;
        if (ec != e.at_edge || index !== e.idx || code_n !== exp_code ||
            running !== e.run || dir !== e.dr || tick !== e.tk) begin
          errors++;
          $display("FAIL event: got edge=%0d index=%0d code_n=%b running=%b dir=%b tick=%b; expected edge=%0d index=%0d code_n=%b running=%b dir=%b tick=%b",
                   ec, index, code_n, running, dir, tick,
                   e.at_edge, e.idx, exp_code, e.run, e.dr, e.tk);
        end
      end
    end
    prev_idx = index;
    prev_run = running;
    prev_dir = dir;
  end

  initial begin
    int e1;
    rst       = 1'b1;
    btn_run_n = 1'b1;
    btn_dir_n = 1'b1;
    @(negedge clk);
    chk("rst_code_n",  32'(code_n),  32'h7);
    chk("rst_index",   32'(index),   32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_dir",     32'(dir),     32'h0);
    chk("rst_tick",    32'(tick),    32'h0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    e1 = ec;

    // Run press: running at +7, then 8+ up-steps every 4 cycles
    btn_run_n = 1'b0;
    push(e1 + 7, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) push(e1 + 7 + 4 * k, 3'(k), 1'b1, 1'b0, 1'b1);
    wait_until(e1 + 12);
    btn_run_n = 1'b1;

    // Two-cycle glitch on both buttons must be ignored
    wait_until(e1 + 40);
    btn_run_n = 1'b0;
    btn_dir_n = 1'b0;
    wait_until(e1 + 42);
    btn_run_n = 1'b1;
    btn_dir_n = 1'b1;

    // Dir press lands while index=0; down-steps wrap 0->7
    wait_until(e1 + 66);
    btn_dir_n = 1'b0;
    push(e1 + 73, 3'd0, 1'b1, 1'b1, 1'b0);
    push(e1 + 75, 3'd7, 1'b1, 1'b1, 1'b1);
    push(e1 + 79, 3'd6, 1'b1, 1'b1, 1'b1);
    push(e1 + 83, 3'd5, 1'b1, 1'b1, 1'b1);
    push(e1 + 87, 3'd4, 1'b1, 1'b1, 1'b1);
    wait_until(e1 + 74);
    btn_dir_n = 1'b1;

    // Pause takes effect with prescaler at 2
    wait_until(e1 + 82);
    btn_run_n = 1'b0;
    push(e1 + 89, 3'd4, 1'b0, 1'b1, 1'b0);
    wait_until(e1 + 90);
    btn_run_n = 1'b1;

    // Resume: first step 2 cycles after running returns
    wait_until(e1 + 120);
    btn_run_n = 1'b0;
    push(e1 + 127, 3'd4, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 7; j++) push(e1 + 129 + 4 * j, 3'(3 - j), 1'b1, 1'b1, 1'b1);
    wait_until(e1 + 128);
    btn_run_n = 1'b1;

    // Mid-operation reset at index 5, prescaler mid-count
    wait_until(e1 + 154);
    rst = 1'b1;
    push(e1 + 155, 3'd0, 1'b0, 1'b0, 1'b0);
    wait_until(e1 + 155);
    rst = 1'b0;

    wait_until(e1 + 185);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding expected 0, next at edge %0d",
               q.size(), q[0].at_edge);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
